// File: rtl/mario_pkg.sv
// Shared constants and animation state type for the Mario sprite fetch block.
package mario_pkg;

    // Sprite box edge length in pixels (sprite ROMs hold SPR_W*SPR_W words)
    localparam int SPR_W = 21;

    // Colour value that marks a transparent sprite pixel
    localparam logic [23:0] TRANSP_RGB = 24'h800080;

    // Walk animation states; the encoding doubles as the ROM select value
    typedef enum logic [1:0] {
        STAND  = 2'd0,
        WALK_1 = 2'd1,
        WALK_2 = 2'd2,
        WALK_3 = 2'd3
    } anim_state_t;

    // Walk cycle order: STAND enters the loop, WALK_3 wraps back to WALK_1
    function automatic anim_state_t next_walk(input anim_state_t s);
        case (s)
            STAND:   return WALK_1;
            WALK_1:  return WALK_2;
            WALK_2:  return WALK_3;
            default: return WALK_1;
        endcase
    endfunction

endpackage

// File: rtl/mario_anim_seq.sv
// Walk-animation sequencer: divides vsync ticks by ANIM_DIV while walking and
// steps through the walk frames; any tick without walking returns to STAND.
module mario_anim_seq #(
    parameter int ANIM_DIV = 4
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       vs_tick,
    input  logic       walking,
    output logic [1:0] anim_frame
);
    import mario_pkg::*;

    localparam int                DIV_W    = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(ANIM_DIV - 1);

    anim_state_t      r_state;
    logic [DIV_W-1:0] r_div;

    // State and divider only move on a vsync tick; between ticks they hold
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= STAND;
            r_div   <= '0;
        end else if (vs_tick) begin
            if (!walking) begin
                r_state <= STAND;
                r_div   <= '0;
            end else if (r_div == DIV_LAST) begin
                r_div   <= '0;
                r_state <= next_walk(r_state);
            end else begin
                r_div   <= r_div + 1'b1;
            end
        end
    end

    assign anim_frame = r_state;

endmodule

// File: rtl/mario_sprite_fetch.sv
// Mario sprite fetch: 2-stage pixel pipeline from VGA coordinate to sprite
// colour, plus a vsync-driven walk animation that selects the ROM frame.
// Optional build macro MARIO_MIRROR_EN: when defined, facing_left=1 mirrors
// the sprite horizontally by addressing column SPR_W-1-col.
module mario_sprite_fetch #(
    parameter int          SPR_W      = mario_pkg::SPR_W,
    parameter int          ANIM_DIV   = 4,
    parameter logic [23:0] TRANSP_RGB = mario_pkg::TRANSP_RGB
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_clk,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic [9:0]  MarioX,
    input  logic [9:0]  MarioY,
    input  logic        walking,
    input  logic        facing_left,
    output logic [8:0]  rom_address,
    output logic [1:0]  anim_frame,
    input  logic [23:0] rom_color,
    output logic        pixel_on,
    output logic [23:0] pixel_rgb
);

    localparam logic signed [10:0] SPR_W_S = 11'(SPR_W);

    logic        r_fclk_s1;
    logic        r_fclk_s2;
    logic        r_fclk_s3;
    logic        w_vs_tick;
    logic [1:0]  w_anim_state;

    logic signed [10:0] w_col;
    logic signed [10:0] w_row;
    logic               w_in_box;
    logic [8:0]         w_col_eff;
    logic [8:0]         w_addr;

    logic        r_in_box_d1;
    logic [8:0]  r_rom_address;
    logic [1:0]  r_anim_frame;
    logic        r_pixel_on;
    logic [23:0] r_pixel_rgb;

    // Two-flop synchroniser on vsync plus a delay flop for rising-edge detect
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_fclk_s1 <= 1'b0;
            r_fclk_s2 <= 1'b0;
            r_fclk_s3 <= 1'b0;
        end else begin
            r_fclk_s1 <= frame_clk;
            r_fclk_s2 <= r_fclk_s1;
            r_fclk_s3 <= r_fclk_s2;
        end
    end

    assign w_vs_tick = r_fclk_s2 & ~r_fclk_s3;

    mario_anim_seq #(
        .ANIM_DIV (ANIM_DIV)
    ) u_anim_seq (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .vs_tick    (w_vs_tick),
        .walking    (walking),
        .anim_frame (w_anim_state)
    );

    // Stage 1 inputs: signed offsets inside the sprite box; negative means outside
    assign w_col    = $signed({1'b0, DrawX}) - $signed({1'b0, MarioX});
    assign w_row    = $signed({1'b0, DrawY}) - $signed({1'b0, MarioY});
    assign w_in_box = !w_col[10] && (w_col < SPR_W_S) && !w_row[10] && (w_row < SPR_W_S);

`ifdef MARIO_MIRROR_EN
    assign w_col_eff = facing_left ? (9'(SPR_W - 1) - w_col[8:0]) : w_col[8:0];
`else
    logic w_unused_facing;
    assign w_unused_facing = facing_left;
    assign w_col_eff       = w_col[8:0];
`endif

    // Only meaningful when in box, where row and col both fit in 5 bits
    assign w_addr = w_row[8:0] * 9'(SPR_W) + w_col_eff;

    // Stage 1: ROM address and frame select registered together so a pixel
    // never combines an address with a frame from a different cycle
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_in_box_d1   <= 1'b0;
            r_rom_address <= '0;
            r_anim_frame  <= '0;
        end else begin
            r_in_box_d1   <= w_in_box;
            r_rom_address <= w_in_box ? w_addr : 9'd0;
            r_anim_frame  <= w_anim_state;
        end
    end

    // Stage 2: transparency key and colour output
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_pixel_on  <= 1'b0;
            r_pixel_rgb <= '0;
        end else begin
            r_pixel_on  <= r_in_box_d1 && (rom_color != TRANSP_RGB);
            r_pixel_rgb <= (r_in_box_d1 && (rom_color != TRANSP_RGB)) ? rom_color : 24'd0;
        end
    end

    assign rom_address = r_rom_address;
    assign anim_frame  = r_anim_frame;
    assign pixel_on    = r_pixel_on;
    assign pixel_rgb   = r_pixel_rgb;

endmodule

// File: tb/tb_mario_sprite_fetch.sv
// Bench for mario_sprite_fetch: directed boundary steps plus randomized
// coordinate streams and walk/stop patterns against a behavioural model.
`timescale 1ns/1ps
module tb_mario_sprite_fetch;

    localparam int          SPR_W    = 21;
    localparam int          ANIM_DIV = 4;
    localparam logic [23:0] TRANSP   = 24'h800080;
`ifdef MARIO_MIRROR_EN
    localparam bit MIRROR = 1'b1;
`else
    localparam bit MIRROR = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        frame_clk = 1'b0;
    logic [9:0]  DrawX = '0, DrawY = '0, MarioX = '0, MarioY = '0;
    logic        walking = 1'b0;
    logic        facing_left = 1'b0;
    logic [8:0]  rom_address;
    logic [1:0]  anim_frame;
    logic [23:0] rom_color;
    logic        pixel_on;
    logic [23:0] pixel_rgb;

    logic        rom_fixed_en = 1'b0;
    logic [23:0] rom_fixed_val = '0;

    int errors = 0;
    int checks = 0;
    int m_frame = 0;
    int m_div = 0;

    mario_sprite_fetch #(
        .SPR_W      (SPR_W),
        .ANIM_DIV   (ANIM_DIV),
        .TRANSP_RGB (TRANSP)
    ) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .frame_clk   (frame_clk),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .MarioX      (MarioX),
        .MarioY      (MarioY),
        .walking     (walking),
        .facing_left (facing_left),
        .rom_address (rom_address),
        .anim_frame  (anim_frame),
        .rom_color   (rom_color),
        .pixel_on    (pixel_on),
        .pixel_rgb   (pixel_rgb)
    );

    always #5 Clk = ~Clk;

    // Synthetic walk-frame ROMs: every 7th word transparent, others tagged by frame/address
    function automatic logic [23:0] rom_fn(input logic [1:0] f, input logic [8:0] a);
        if ((a % 7) == 3) return TRANSP;
        return {4'hA, f, a, 9'h155};
    endfunction

    always_comb rom_color = rom_fixed_en ? rom_fixed_val : rom_fn(anim_frame, rom_address);

    function automatic bit ref_in_box(input int dx, input int dy, input int mx, input int my);
        return (dx - mx >= 0) && (dx - mx < SPR_W) && (dy - my >= 0) && (dy - my < SPR_W);
    endfunction

    function automatic int ref_addr(input int dx, input int dy, input int mx, input int my, input bit fl);
        int c;
        c = dx - mx;
        if (!ref_in_box(dx, dy, mx, my)) return 0;
        if (MIRROR && fl) c = SPR_W - 1 - c;
        return (dy - my) * SPR_W + c;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // One vsync pulse, long enough for the synchroniser and frame register to settle
    task automatic vs_pulse();
        frame_clk = 1'b1;
        repeat (4) step();
        frame_clk = 1'b0;
        repeat (4) step();
        if (walking) begin
            if (m_div == ANIM_DIV - 1) begin
                m_div   = 0;
                m_frame = (m_frame == 3) ? 1 : m_frame + 1;
            end else begin
                m_div++;
            end
        end else begin
            m_frame = 0;
            m_div   = 0;
        end
    endtask

    int  bdx [8] = '{99, 121, 100, 120, 105, 105, 105, 105};
    int  bdy [8] = '{203, 203, 203, 203, 199, 221, 200, 220};
    int  bad [8] = '{0, 0, 63, 83, 0, 0, 5, 425};
    bit  bin [8] = '{0, 0, 1, 1, 0, 0, 1, 1};

    bit  prev_in, cur_in, exp_on;
    int  prev_addr, cur_addr;

    initial begin
        // Reset state while an in-box coordinate is presented
        MarioX = 10'd100; MarioY = 10'd200; DrawX = 10'd105; DrawY = 10'd203;
        repeat (3) step();
        check("rst_addr",  rom_address, 0);
        check("rst_frame", anim_frame, 0);
        check("rst_on",    pixel_on, 0);
        check("rst_rgb",   pixel_rgb, 0);
        #3 Reset_n = 1'b1;

        // First in-box coordinate after release: address after 1, pixel after 2
        step();
        check("addr_68",      rom_address, 68);
        check("first_on_lat", pixel_on, 0);
        step();
        check("first_on",  pixel_on, 1);
        check("first_rgb", pixel_rgb, rom_fn(2'd0, 9'd68));

        // Transparency key versus opaque colour
        rom_fixed_en = 1'b1; rom_fixed_val = TRANSP;
        step(); step();
        check("transp_on",  pixel_on, 0);
        check("transp_rgb", pixel_rgb, 0);
        rom_fixed_val = 24'hF83800;
        step(); step();
        check("opaque_on",  pixel_on, 1);
        check("opaque_rgb", pixel_rgb, 24'hF83800);

        // Box edges in both axes
        for (int i = 0; i < 8; i++) begin
            DrawX = 10'(bdx[i]); DrawY = 10'(bdy[i]);
            step();
            check("edge_addr", rom_address, bad[i]);
            step();
            check("edge_on", pixel_on, 32'(bin[i]));
        end

        // Facing left at the top-left corner
        facing_left = 1'b1; DrawX = 10'd100; DrawY = 10'd200;
        step();
        check("mirror_addr", rom_address, MIRROR ? 20 : 0);
        facing_left = 1'b0;
        rom_fixed_en = 1'b0;

        // Walk animation with walking held
        walking = 1'b1;
        for (int i = 0; i < 26; i++) begin
            vs_pulse();
            check("walk_frame", anim_frame, 32'(m_frame));
        end
        walking = 1'b0;
        vs_pulse();
        check("stop_frame", anim_frame, 0);

        // Random walk/stop pattern
        for (int i = 0; i < 20; i++) begin
            walking = ($urandom_range(0, 3) != 0);
            vs_pulse();
            check("rand_frame", anim_frame, 32'(m_frame));
        end

        // Random coordinate stream, one pixel per cycle
        DrawX = 10'd0; DrawY = 10'd0; MarioX = 10'd500; MarioY = 10'd300;
        step(); step();
        prev_in = 1'b0; prev_addr = 0;
        for (int i = 0; i < 200; i++) begin
            if (i % 20 == 0) begin
                MarioX = 10'($urandom_range(10, 900));
                MarioY = 10'($urandom_range(10, 450));
            end
            if ($urandom_range(0, 7) == 0) begin
                DrawX = 10'($urandom_range(0, 1023));
                DrawY = 10'($urandom_range(0, 1023));
            end else begin
                DrawX = 10'(int'(MarioX) + int'($urandom_range(0, 26)) - 3);
                DrawY = 10'(int'(MarioY) + int'($urandom_range(0, 26)) - 3);
            end
            facing_left = 1'($urandom_range(0, 1));
            cur_in   = ref_in_box(int'(DrawX), int'(DrawY), int'(MarioX), int'(MarioY));
            cur_addr = ref_addr(int'(DrawX), int'(DrawY), int'(MarioX), int'(MarioY), facing_left);
            step();
            check("rand_addr", rom_address, cur_addr);
            exp_on = prev_in && (rom_fn(2'(m_frame), 9'(prev_addr)) != TRANSP);
            check("rand_on",  pixel_on, 32'(exp_on));
            check("rand_rgb", pixel_rgb, exp_on ? 32'(rom_fn(2'(m_frame), 9'(prev_addr))) : 32'd0);
            prev_in = cur_in; prev_addr = cur_addr;
        end
        check("frame_stable", anim_frame, 32'(m_frame));
        facing_left = 1'b0;

        // Reset asserted in WALK_2 while a pixel is on
        walking = 1'b1;
        for (int k = 0; k < 24 && m_frame != 2; k++) vs_pulse();
        check("walk2_frame", anim_frame, 2);
        MarioX = 10'd100; MarioY = 10'd200; DrawX = 10'd105; DrawY = 10'd203;
        rom_fixed_en = 1'b1; rom_fixed_val = 24'hF83800;
        step(); step();
        check("pre_rst_on", pixel_on, 1);
        #2 Reset_n = 1'b0;
        #1;
        check("async_on",    pixel_on, 0);
        check("async_rgb",   pixel_rgb, 0);
        check("async_addr",  rom_address, 0);
        check("async_frame", anim_frame, 0);
        step();
        check("held_on", pixel_on, 0);
        #3 Reset_n = 1'b1;
        m_frame = 0; m_div = 0;
        step();
        check("rel_addr", rom_address, 68);
        check("rel_on0",  pixel_on, 0);
        step();
        check("rel_on1",  pixel_on, 1);
        for (int i = 0; i < ANIM_DIV - 1; i++) begin
            vs_pulse();
            check("hold_stand", anim_frame, 0);
        end
        vs_pulse();
        check("after_div", anim_frame, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mario_sprite_fetch.md
MARIO_SPRITE_FETCH -- requirements
Module: mario_sprite_fetch

Interface
REQ-001 Parameter: SPR_W, 21, sprite width and height in pixels; a sprite is SPR_W*SPR_W = 441 words.
REQ-002 Parameter: ANIM_DIV, 4, number of frame_clk rising edges per walk-animation step.
REQ-003 Parameter: TRANSP_RGB, 24'h800080, colour value that marks a transparent pixel.
REQ-004 Port: Clk  in  1  system clock; all logic is on its rising edge.
REQ-005 Port: Reset_n  in  1  asynchronous, active-low reset.
REQ-006 Port: frame_clk  in  1  VGA vsync, sampled by Clk.
REQ-007 Port: DrawX, DrawY  in  10 each  current pixel coordinate from the VGA controller.
REQ-008 Port: MarioX, MarioY  in  10 each  top-left corner of the sprite box.
REQ-009 Port: walking  in  1  Mario is moving horizontally.
REQ-010 Port: facing_left  in  1  Mario faces left.
REQ-011 Port: rom_address  out  9  read address to the walk-frame ROMs.
REQ-012 Port: anim_frame  out  2  ROM select: 0 = stand, 1..3 = walk_right_1..3.
REQ-013 Port: rom_color  in  24  combinational ROM colour for rom_address.
REQ-014 Port: pixel_on  out  1  Mario covers the pixel.
REQ-015 Port: pixel_rgb  out  24  Mario colour for the pixel.

Function
REQ-016 frame_clk SHALL pass through a 2-flop synchroniser; a rising edge SHALL be detected as one Clk-wide pulse (vs_tick).
REQ-017 Animation FSM states SHALL be STAND, WALK_1, WALK_2 and WALK_3; anim_frame SHALL encode them as 0, 1, 2 and 3.
REQ-018 A divider counter, 0..ANIM_DIV-1, SHALL increment on vs_tick only while walking=1; on reaching ANIM_DIV-1 it SHALL wrap to 0 and advance the state.
REQ-019 Transitions: STAND->WALK_1; WALK_1->WALK_2; WALK_2->WALK_3; WALK_3->WALK_1 (wrap-around that never returns to STAND).
REQ-020 On a vs_tick with walking=0, the FSM SHALL go to STAND and clear the divider; the FSM SHALL not change between vs_ticks.
REQ-021 Stage 1 (registered) SHALL compute col = DrawX-MarioX and row = DrawY-MarioY in 11-bit signed arithmetic.
REQ-022 in_box SHALL be set iff 0 <= col < SPR_W and 0 <= row < SPR_W; a negative difference is outside the box.
REQ-023 When in_box=1, rom_address SHALL be row*SPR_W + col (range 0..440); otherwise it SHALL be 0.
REQ-024 anim_frame SHALL be registered with rom_address so the two change on the same edge.
REQ-025 Stage 2 (registered) SHALL set pixel_on = in_box_d1 AND (rom_color != TRANSP_RGB), and pixel_rgb = rom_color when pixel_on=1, else 0.
REQ-026 Latency from DrawX/DrawY to pixel_on/pixel_rgb SHALL be exactly 2 Clk cycles; throughput SHALL be one pixel per cycle.
REQ-027 If vs_tick coincides with an in-box pixel, the new anim_frame SHALL apply from the next Clk edge; no pixel SHALL mix ROM data from two frames.

Reset
REQ-028 Reset_n=0 SHALL asynchronously force: FSM=STAND, divider=0, synchroniser flops=0, rom_address=0, anim_frame=0, in_box pipeline=0, pixel_on=0, pixel_rgb=0.
REQ-029 A reset asserted mid-frame SHALL drop pixel_on within the same cycle; after release, the first valid pixel_on SHALL appear 2 cycles after the first in-box coordinate.

Configuration
REQ-030 With MARIO_MIRROR_EN defined, col SHALL be replaced by SPR_W-1-col when facing_left=1, so the right-facing ROMs are drawn mirrored.
REQ-031 Without MARIO_MIRROR_EN, facing_left SHALL be ignored and the address SHALL always use the unmirrored col.

Structure
REQ-032 Package mario_pkg SHALL hold the SPR_W and TRANSP_RGB constants and the anim_state_t enum (STAND, WALK_1, WALK_2, WALK_3).
REQ-033 The animation FSM and divider SHALL be the sub-module mario_anim_seq (inputs: Clk, Reset_n, vs_tick, walking; output: anim_frame); the address pipeline SHALL stay in the top module.

Verification
REQ-034 MarioX=100, MarioY=200, DrawX=105, DrawY=203 -> rom_address=68 one cycle later; pixel_on follows rom_color two cycles later.
REQ-035 DrawX=99 or DrawX=121 with MarioX=100 -> in_box=0, rom_address=0, pixel_on=0; DrawX=100/120 -> in box, rom_address=row*21+0 and row*21+20.
REQ-036 walking=1 held, ANIM_DIV=4 -> anim_frame sequence 0,1,2,3,1,2,3 with each step after 4 vsync pulses; walking=0 -> anim_frame=0 at the next vsync pulse.
REQ-037 rom_color=24'h800080 while in box -> pixel_on=0, pixel_rgb=0; rom_color=24'hF83800 -> pixel_on=1, pixel_rgb=24'hF83800.
REQ-038 With MARIO_MIRROR_EN and facing_left=1, col=0,row=0 -> rom_address=20; without the macro -> rom_address=0.
REQ-039 Reset_n pulled low during WALK_2 with pixel_on=1 -> all outputs 0 immediately; after release, anim_frame=0 until the divider completes.
